// File: rtl/burst_scheduler.sv
// burst_scheduler
// Two-requester burst arbiter. A requester with a nonzero mode wins a grant,
// streams up to BURST_LEN beats toward a downstream FIFO through a one-cycle
// registered mux, and releases the grant on completion or when its mode drops.
// Ownership alternates between the requesters whenever both are asking.

module burst_scheduler #(
    parameter int DW        = 32,
    parameter int BURST_LEN = 16
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [1:0]    slv0_mode,
    input  logic          slv0_data_valid,
    input  logic [DW-1:0] slv0_data,
    input  logic [7:0]    slv0_proc_val,
    output logic          slv0_ready,

    input  logic [1:0]    slv1_mode,
    input  logic          slv1_data_valid,
    input  logic [DW-1:0] slv1_data,
    input  logic [7:0]    slv1_proc_val,
    output logic          slv1_ready,

    input  logic          fifo_full,
    input  logic          mstr_cmplt,

    output logic [1:0]    slvx_mode,
    output logic [DW-1:0] slvx_data,
    output logic [7:0]    slvx_proc_val,
    output logic          slvx_data_valid,

    output logic [1:0]    grant,
    output logic          burst_done,
    output logic          burst_abort
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Index of the final beat; BURST_LEN is limited to 2..256 so it fits 8 bits.
    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    // Control state
    state_t        r_state;
    logic          r_ptr;      // 0: slv0 wins a tie, 1: slv1 wins a tie
    logic [7:0]    r_cnt;      // beats accepted in the current burst
    logic [1:0]    r_mode;     // mode captured at grant time
    logic [1:0]    r_grant;
    logic          r_done;
    logic          r_abort;

    // Forwarded beat
    logic [DW-1:0] r_xdata;
    logic [7:0]    r_xpv;
    logic          r_xvalid;

    // Combinational decode
    logic          w_req0;
    logic          w_req1;
    logic          w_pick;     // requester chosen in IDLE: 0 = slv0, 1 = slv1
    logic          w_owner;    // current owner: 0 = slv0, 1 = slv1
    logic          w_xfer;
    logic          w_stall;
    logic          w_accept;
    logic          w_mode_drop;
    logic [1:0]    w_own_mode;

    assign w_req0      = |slv0_mode;
    assign w_req1      = |slv1_mode;
    assign w_pick      = (w_req0 && w_req1) ? r_ptr : w_req1;
    assign w_owner     = r_grant[1];
    assign w_xfer      = (r_state == ST_XFER);
    assign w_stall     = fifo_full | mstr_cmplt;

    assign slv0_ready  = r_grant[0] & w_xfer & ~w_stall;
    assign slv1_ready  = r_grant[1] & w_xfer & ~w_stall;

    assign w_accept    = (slv0_ready & slv0_data_valid) | (slv1_ready & slv1_data_valid);
    assign w_own_mode  = w_owner ? slv1_mode : slv0_mode;
    assign w_mode_drop = (w_own_mode == 2'b00);

    // Arbitration FSM: grant, beat counting, pause on back-pressure, end-of-burst pulses
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register here uses <= so all of them see the same pre-edge
        // values; blocking assignments would make the result depend on statement order.
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
            r_cnt   <= '0;
            r_mode  <= '0;
            r_grant <= '0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!mstr_cmplt && (w_req0 || w_req1)) begin
                        r_state <= ST_XFER;
                        r_grant <= w_pick ? 2'b10 : 2'b01;
                        r_mode  <= w_pick ? slv1_mode : slv0_mode;
                        r_cnt   <= '0;
                    end
                end
                ST_XFER: begin
                    if (w_mode_drop) begin
                        // A beat accepted this cycle is still forwarded by the datapath.
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_ptr   <= ~w_owner;
                        r_abort <= 1'b1;
                    end else if (w_accept && (r_cnt == LAST_BEAT)) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_ptr   <= ~w_owner;
                        r_done  <= 1'b1;
                    end else begin
                        if (w_accept) begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                        // Ready is already gated by the stall, so no beat is lost here.
                        if (w_stall) begin
                            r_state <= ST_PAUSE;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (w_mode_drop) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_ptr   <= ~w_owner;
                        r_abort <= 1'b1;
                    end else if (!w_stall) begin
                        r_state <= ST_XFER;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Beat forwarding register: valid for exactly one cycle per accepted beat, data held otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_xvalid <= 1'b0;
            r_xdata  <= '0;
            r_xpv    <= '0;
        end else begin
            r_xvalid <= w_accept;
            if (w_accept) begin
                r_xdata <= w_owner ? slv1_data     : slv0_data;
                r_xpv   <= w_owner ? slv1_proc_val : slv0_proc_val;
            end
        end
    end

    assign slvx_mode       = r_mode;
    assign slvx_data       = r_xdata;
    assign slvx_proc_val   = r_xpv;
    assign slvx_data_valid = r_xvalid;
    assign grant           = r_grant;
    assign burst_done      = r_done;
    assign burst_abort     = r_abort;

endmodule

// File: tb/tb_burst_scheduler.sv
// tb_burst_scheduler
// Directed stimulus for burst_scheduler. Every accepted beat is pushed into a
// scoreboard queue with the data the bench drove; an independent monitor pops
// and compares whenever the DUT presents a forwarded beat.

module tb_burst_scheduler;

    localparam int DW = 32;
    localparam int BL = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    slv0_mode, slv1_mode;
    logic          slv0_data_valid, slv1_data_valid;
    logic [DW-1:0] slv0_data, slv1_data;
    logic [7:0]    slv0_proc_val, slv1_proc_val;
    logic          slv0_ready, slv1_ready;
    logic          fifo_full, mstr_cmplt;
    logic [1:0]    slvx_mode;
    logic [DW-1:0] slvx_data;
    logic [7:0]    slvx_proc_val;
    logic          slvx_data_valid;
    logic [1:0]    grant;
    logic          burst_done, burst_abort;

    burst_scheduler #(.DW(DW), .BURST_LEN(BL)) dut (
        .clk             (clk),
        .rst             (rst),
        .slv0_mode       (slv0_mode),
        .slv0_data_valid (slv0_data_valid),
        .slv0_data       (slv0_data),
        .slv0_proc_val   (slv0_proc_val),
        .slv0_ready      (slv0_ready),
        .slv1_mode       (slv1_mode),
        .slv1_data_valid (slv1_data_valid),
        .slv1_data       (slv1_data),
        .slv1_proc_val   (slv1_proc_val),
        .slv1_ready      (slv1_ready),
        .fifo_full       (fifo_full),
        .mstr_cmplt      (mstr_cmplt),
        .slvx_mode       (slvx_mode),
        .slvx_data       (slvx_data),
        .slvx_proc_val   (slvx_proc_val),
        .slvx_data_valid (slvx_data_valid),
        .grant           (grant),
        .burst_done      (burst_done),
        .burst_abort     (burst_abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
        logic [7:0]    pv;
        logic [1:0]    mode;
    } beat_t;

    beat_t         sb_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            n0 = 0, n1 = 0;
    bit            adv0 = 0, adv1 = 0;
    logic [1:0]    exp_mode0 = '0, exp_mode1 = '0;
    int            burst_beats = 0, burst_first = 0, burst_last = 0;
    logic [DW-1:0] last_data = '0;

    // Each requester presents a distinct, incrementing beat pattern.
    assign slv0_data     = 32'hA000_0000 + n0;
    assign slv0_proc_val = 8'(n0 + 8'h40);
    assign slv1_data     = 32'hB000_0000 + n1;
    assign slv1_proc_val = 8'(n1 + 8'h80);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycle counter
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Source side: record handshakes as expected beats, advance the pattern after the edge
    initial begin
        beat_t b;
        forever begin
            @(negedge clk);
            check("ready_exclusive", 64'(slv0_ready & slv1_ready), 64'd0);
            if (slv0_ready && slv0_data_valid) begin
                b.cyc = cyc; b.data = slv0_data; b.pv = slv0_proc_val; b.mode = exp_mode0;
                sb_q.push_back(b);
                adv0 = 1;
            end
            if (slv1_ready && slv1_data_valid) begin
                b.cyc = cyc; b.data = slv1_data; b.pv = slv1_proc_val; b.mode = exp_mode1;
                sb_q.push_back(b);
                adv1 = 1;
            end
            if (adv0 || adv1) begin
                burst_beats++;
                if (burst_beats == 1) burst_first = cyc;
                burst_last = cyc;
                last_data  = b.data;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (adv0) begin n0++; adv0 = 0; end
        if (adv1) begin n1++; adv1 = 0; end
    end

    // Monitor: every forwarded beat must match the oldest expected beat, one cycle later
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (slvx_data_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("beat_latency", 64'(cyc), 64'(e.cyc + 1));
                    check("beat_data", 64'(slvx_data), 64'(e.data));
                    check("beat_proc_val", 64'(slvx_proc_val), 64'(e.pv));
                    check("beat_mode", 64'(slvx_mode), 64'(e.mode));
                end
            end
        end
    end

    task automatic wait_grant(input logic [1:0] exp_g, input int budget, input string nm);
        int k = 0;
        while (grant == 2'b00 && k < budget) begin
            step();
            k++;
        end
        check(nm, 64'(grant), 64'(exp_g));
        burst_beats = 0;
    endtask

    task automatic wait_beats(input int n, input string nm);
        int k = 0;
        while (burst_beats < n && k < 100) begin
            step();
            k++;
        end
        check(nm, 64'(burst_beats), 64'(n));
    endtask

    task automatic wait_done(input string nm, input int exp_beats);
        int k = 0;
        while (!burst_done && !burst_abort && k < 100) begin
            step();
            k++;
        end
        check({nm, "_done"}, 64'(burst_done), 64'd1);
        check({nm, "_abort_low"}, 64'(burst_abort), 64'd0);
        check({nm, "_grant_clear"}, 64'(grant), 64'd0);
        check({nm, "_beats"}, 64'(burst_beats), 64'(exp_beats));
        check({nm, "_done_timing"}, 64'(cyc), 64'(burst_last + 1));
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_grant"}, 64'(grant), 64'd0);
        check({nm, "_ready0"}, 64'(slv0_ready), 64'd0);
        check({nm, "_ready1"}, 64'(slv1_ready), 64'd0);
        check({nm, "_xvalid"}, 64'(slvx_data_valid), 64'd0);
        check({nm, "_xdata"}, 64'(slvx_data), 64'd0);
        check({nm, "_xpv"}, 64'(slvx_proc_val), 64'd0);
        check({nm, "_xmode"}, 64'(slvx_mode), 64'd0);
        check({nm, "_done"}, 64'(burst_done), 64'd0);
        check({nm, "_abort"}, 64'(burst_abort), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with slv0 already requesting: outputs must stay zero
        rst = 1'b1;
        slv0_mode = 2'd1; slv0_data_valid = 1'b1; exp_mode0 = 2'd1;
        slv1_mode = 2'd0; slv1_data_valid = 1'b0;
        fifo_full = 1'b0; mstr_cmplt = 1'b0;
        repeat (3) step();
        check_all_zero("reset");

        // Single requester, full burst of consecutive beats
        rst = 1'b0;
        step();
        wait_grant(2'b01, 0, "A_grant");
        wait_done("A", BL);
        check("A_consecutive", 64'(burst_last - burst_first), 64'(BL - 1));
        slv0_mode = 2'd0;
        step();
        check("A_idle_no_grant", 64'(grant), 64'd0);
        check("A_done_single", 64'(burst_done), 64'd0);

        // Both requesting continuously: slv0, slv1, slv0 with one idle cycle between
        rst = 1'b1;
        slv0_mode = 2'd2; exp_mode0 = 2'd2;
        slv1_mode = 2'd3; exp_mode1 = 2'd3; slv1_data_valid = 1'b1;
        step();
        rst = 1'b0;
        step();
        wait_grant(2'b01, 0, "B_grant0");
        wait_done("B0", BL);
        step();
        check("B_done_single", 64'(burst_done), 64'd0);
        wait_grant(2'b10, 0, "B_grant1");
        wait_done("B1", BL);
        step();
        wait_grant(2'b01, 0, "B_grant2");
        wait_done("B2", BL);

        // FIFO back-pressure for three cycles after beat 5
        slv1_mode = 2'd0; slv1_data_valid = 1'b0;
        step();
        wait_grant(2'b01, 0, "C_grant");
        wait_beats(5, "C_beats5");
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("C_ready_stall", 64'(slv0_ready), 64'd0);
            if (i == 2) begin
                check("C_count_hold", 64'(burst_beats), 64'd5);
                check("C_xvalid_low", 64'(slvx_data_valid), 64'd0);
                check("C_xdata_hold", 64'(slvx_data), 64'(last_data));
            end
            step();
        end
        fifo_full = 1'b0;
        wait_done("C", BL);

        // slv1 mode drops after beat 7: abort, then slv0 gets the next grant
        slv1_mode = 2'd1; exp_mode1 = 2'd1; slv1_data_valid = 1'b1;
        step();
        wait_grant(2'b10, 0, "D_grant");
        wait_beats(7, "D_beats7");
        slv1_mode = 2'd0; slv1_data_valid = 1'b0;
        step();
        check("D_abort", 64'(burst_abort), 64'd1);
        check("D_done_low", 64'(burst_done), 64'd0);
        check("D_grant_clear", 64'(grant), 64'd0);
        check("D_beats", 64'(burst_beats), 64'd7);
        step();
        check("D_abort_single", 64'(burst_abort), 64'd0);
        wait_grant(2'b01, 0, "D_next_grant");

        // Mode drop in the same cycle as an accepted beat: beat forwarded, then abort
        wait_beats(3, "E_beats3");
        slv0_mode = 2'd0;
        step();
        check("E_abort", 64'(burst_abort), 64'd1);
        check("E_grant_clear", 64'(grant), 64'd0);
        check("E_beats", 64'(burst_beats), 64'd4);
        step();
        check("E_ready_off", 64'(slv0_ready), 64'd0);
        check("E_no_regrant", 64'(grant), 64'd0);

        // mstr_cmplt blocks granting in IDLE; grant follows the cycle after release
        mstr_cmplt = 1'b1;
        slv0_mode = 2'd1; exp_mode0 = 2'd1;
        slv1_mode = 2'd1; exp_mode1 = 2'd1; slv1_data_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("F_blocked", 64'(grant), 64'd0);
        end
        mstr_cmplt = 1'b0;
        step();
        wait_grant(2'b10, 0, "F_grant");

        // Reset mid-burst at beat 9: outputs clear at once, no end pulse, slv0 wins afterwards
        wait_beats(9, "G_beats9");
        rst = 1'b1;
        #1;
        check_all_zero("G_reset");
        sb_q.delete();
        step();
        check("G_no_done", 64'(burst_done), 64'd0);
        check("G_no_abort", 64'(burst_abort), 64'd0);
        rst = 1'b0;
        step();
        wait_grant(2'b01, 0, "G_grant");
        wait_done("G", BL);

        slv0_mode = 2'd0; slv1_mode = 2'd0;
        repeat (3) step();
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/burst_scheduler.md
BURST_SCHEDULER -- requirements
Module: burst_scheduler

Interface
REQ-001 Parameter DW, default 32, pixel data width in bits.
REQ-002 Parameter BURST_LEN, default 16, beats per grant; legal range 2..256.
REQ-003 Port clk  in  1  single clock; all state changes on rising edge.
REQ-004 Port rst  in  1  reset, asynchronous and active-high.
REQ-005 Ports slv0_mode / slv1_mode  in  2  per-requester processing mode; nonzero means requesting.
REQ-006 Ports slv0_data_valid / slv1_data_valid  in  1  beat present on the requester's data bus.
REQ-007 Ports slv0_data / slv1_data  in  DW  requester pixel data.
REQ-008 Ports slv0_proc_val / slv1_proc_val  in  8  requester processing value.
REQ-009 Ports slv0_ready / slv1_ready  out  1  beat accept, combinational.
REQ-010 Port fifo_full  in  1  downstream FIFO cannot take a beat this cycle.
REQ-011 Port mstr_cmplt  in  1  master busy completing a job; blocks all transfers.
REQ-012 Ports slvx_mode (2), slvx_data (DW), slvx_proc_val (8), slvx_data_valid (1)  out  registered muxed beat toward the FIFO.
REQ-013 Port grant  out  2  one-hot owner (bit0 = slv0, bit1 = slv1), 0 when idle.
REQ-014 Ports burst_done / burst_abort  out  1  single-cycle end-of-burst pulses.

Function
REQ-015 FSM states are IDLE, XFER and PAUSE; state encoding is not visible at the ports.
REQ-016 In IDLE with mstr_cmplt=0, a grant is issued next cycle to a requester with nonzero mode, and the state moves to XFER.
REQ-017 If both requesters are active, the one not granted last receives the grant; the priority pointer after reset favours slv0.
REQ-018 At grant time the requester's mode is latched; slvx_mode carries the latched value for the whole burst.
REQ-019 slvN_ready = grant[N] & (state==XFER) & ~fifo_full & ~mstr_cmplt; the non-granted ready is always 0.
REQ-020 A beat is accepted when slvN_ready & slvN_data_valid in the same cycle.
REQ-021 An accepted beat appears on slvx_data/slvx_proc_val with slvx_data_valid=1 exactly one cycle later; slvx_data_valid is 0 in every other cycle and slvx_data holds its last value.
REQ-022 An 8-bit-wide-or-larger beat counter increments per accepted beat and clears at grant.
REQ-023 XFER goes to PAUSE when fifo_full or mstr_cmplt is 1; PAUSE returns to XFER the cycle after both are 0; the counter holds in PAUSE.
REQ-024 Acceptance of beat BURST_LEN-1 means the next cycle has burst_done=1, grant=0, state IDLE, and the pointer updated to the other requester.
REQ-025 If the granted requester's mode drops to 0 during XFER or PAUSE, the next cycle has burst_abort=1, grant=0, state IDLE, and the pointer updated; no further beats are accepted from it.
REQ-026 If beat acceptance and a mode drop occur in the same cycle, the beat is forwarded and the abort rule applies.
REQ-027 A new grant is never issued in the same cycle as burst_done or burst_abort; there is at least one IDLE cycle between bursts.
REQ-028 fifo_full asserted in IDLE does not block granting; it only gates ready.

Reset
REQ-029 While rst=1, all outputs are 0, state is IDLE, the counter is 0, and the pointer favours slv0, independent of clk.
REQ-030 Reset asserted mid-burst discards the burst without a burst_done or burst_abort pulse; after release, granting resumes from REQ-016.

Verification
REQ-031 Single requester: slv0_mode=1, data_valid held 1, BURST_LEN=16 -> 16 consecutive slvx_data_valid pulses, each one cycle after acceptance; burst_done on the cycle after the 16th acceptance.
REQ-032 Both requesting continuously -> grants alternate slv0, slv1, slv0, with one IDLE cycle between bursts.
REQ-033 fifo_full=1 for 3 cycles after beat 5 -> ready=0 for those 3 cycles; the counter holds at 5; the burst resumes and ends after exactly 16 beats.
REQ-034 slv1 mode drops to 0 after beat 7 -> burst_abort pulse, grant=0, the next grant goes to slv0 if it is requesting.
REQ-035 mstr_cmplt=1 in IDLE with both requesting -> no grant until mstr_cmplt=0, then a grant follows next cycle.
REQ-036 rst pulsed mid-burst at beat 9 -> outputs zero immediately; after release, slv0 wins a simultaneous request.
